// File: rtl/ws2812_rx.sv
// WS2812 single-wire NRZ receive decoder: measures high pulses, assembles GRB pixels,
// flags frame end on the long low latch gap and forwards post-first-pixel bits to dout.
module ws2812_rx #(
  parameter int unsigned BIT_THRESH_TICKS = 30,
  parameter int unsigned MIN_HIGH_TICKS   = 8,
  parameter int unsigned MAX_HIGH_TICKS   = 60,
  parameter int unsigned RESET_TICKS      = 2500,
  parameter int unsigned CNT_W            = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       pixel_valid,
  output logic [7:0] pixel_index,
  output logic       frame_done,
  output logic       bit_error,
  output logic       dout
);

  localparam int unsigned BCNT_W = 5;
  localparam int unsigned SHR_W  = 23;

  localparam logic [CNT_W-1:0]  THRESH_C   = CNT_W'(BIT_THRESH_TICKS);
  localparam logic [CNT_W-1:0]  MIN_C      = CNT_W'(MIN_HIGH_TICKS);
  localparam logic [CNT_W-1:0]  MAX_C      = CNT_W'(MAX_HIGH_TICKS);
  localparam logic [CNT_W-1:0]  RESET_C    = CNT_W'(RESET_TICKS);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [BCNT_W-1:0] LAST_BIT_C = BCNT_W'(23);

  typedef enum logic [2:0] {SYNC, IDLE, HIGH, LOW, ERR} state_t;

  state_t             state_q, state_d;
  logic               meta_q, ds, ds_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [SHR_W-1:0]   shreg_q, shreg_d;
  logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic               fwd_en_q, fwd_en_d;
  logic [7:0]         r_d, g_d, b_d, idx_d;
  logic               pixel_valid_d, frame_done_d, bit_error_d, dout_d;
  logic               rise, fall, bit_val;
  logic [SHR_W:0]     shifted;

  // Next-state, datapath and output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    fwd_en_d      = fwd_en_q;
    r_d           = r;
    g_d           = g;
    b_d           = b;
    idx_d         = pixel_valid ? pixel_index + 8'd1 : pixel_index;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    bit_error_d   = 1'b0;

    rise    = ds & ~ds_q;
    fall    = ~ds & ds_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    bit_val = (cnt_q >= THRESH_C);
    shifted = {shreg_q, bit_val};
    // A forwarded high may only start on a rising edge seen while forwarding is enabled
    dout_d  = ds & fwd_en_q & (dout | rise);

    unique case (state_q)
      SYNC, ERR: begin
        if (ds) begin
          cnt_d = '0;
        end else if (cnt_q >= RESET_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          if (cnt_q < MIN_C) begin
            state_d     = ERR;
            cnt_d       = '0;
            bit_cnt_d   = '0;
            fwd_en_d    = 1'b0;
            bit_error_d = 1'b1;
          end else begin
            state_d = LOW;
            cnt_d   = CNT_ONE;
            shreg_d = shifted[SHR_W-1:0];
            if (bit_cnt_q == LAST_BIT_C) begin
              g_d           = shifted[23:16];
              r_d           = shifted[15:8];
              b_d           = shifted[7:0];
              pixel_valid_d = 1'b1;
              bit_cnt_d     = '0;
              fwd_en_d      = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            end
          end
        end else if (cnt_q >= MAX_C) begin
          state_d     = ERR;
          cnt_d       = '0;
          bit_cnt_d   = '0;
          fwd_en_d    = 1'b0;
          bit_error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOW: begin
        // Latch gap wins over a coincident rising edge, which then starts the next bit
        if (cnt_q == RESET_C) begin
          frame_done_d = 1'b1;
          bit_error_d  = (bit_cnt_q != '0);
          idx_d        = '0;
          bit_cnt_d    = '0;
          fwd_en_d     = 1'b0;
          state_d      = rise ? HIGH : IDLE;
          cnt_d        = rise ? CNT_ONE : '0;
        end else if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchronizer, state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= 1'b0;
      ds          <= 1'b0;
      ds_q        <= 1'b0;
      state_q     <= SYNC;
      cnt_q       <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      fwd_en_q    <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      dout        <= 1'b0;
    end else begin
      meta_q      <= din;
      ds          <= meta_q;
      ds_q        <= ds;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      fwd_en_q    <= fwd_en_d;
      r           <= r_d;
      g           <= g_d;
      b           <= b_d;
      pixel_valid <= pixel_valid_d;
      pixel_index <= idx_d;
      frame_done  <= frame_done_d;
      bit_error   <= bit_error_d;
      dout        <= dout_d;
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: scoreboarded pixels, event counters and a dout replay model.
module tb_ws2812_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic [7:0] r, g, b, pixel_index;
  logic       pixel_valid, frame_done, bit_error, dout;

  ws2812_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .r           (r),
    .g           (g),
    .b           (b),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .bit_error   (bit_error),
    .dout        (dout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard entries are {g, r, b, pixel_index}
  logic [31:0] exp_q[$];

  int   n_fd = 0, n_be = 0, n_both = 0, n_drise = 0, dout_mism = 0;
  logic fwd_exp = 1'b0;
  logic h1 = 1'b0, h2 = 1'b0, dout_prev = 1'b0;

  // Output monitor, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (pixel_valid) begin
      if (exp_q.size() == 0) check("pixel_unexpected", 32'(exp_q.size()), 32'd1);
      else check("pixel", {g, r, b, pixel_index}, exp_q.pop_front());
    end
    if (frame_done) n_fd++;
    if (bit_error) n_be++;
    if (frame_done && bit_error) n_both++;
    if (dout !== (fwd_exp ? h2 : 1'b0)) dout_mism++;
    if (dout && !dout_prev) n_drise++;
    dout_prev = dout;
    h2 = h1;
    h1 = din;
  end

  int base_fd, base_be, base_both;

  task automatic mark();
    base_fd   = n_fd;
    base_be   = n_be;
    base_both = n_both;
  endtask

  task automatic expect_events(input string tag, input int fd, input int be, input int both);
    check({tag, "_frame_done"}, 32'(n_fd - base_fd), 32'(fd));
    check({tag, "_bit_error"}, 32'(n_be - base_be), 32'(be));
    check({tag, "_coincident"}, 32'(n_both - base_both), 32'(both));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int hi, input int lo);
    din = 1'b1;
    tick(hi);
    din = 1'b0;
    tick(lo);
  endtask

  task automatic send_bits(input logic [23:0] px, input int top, input int n,
                           input int oh, input int ol, input int zh, input int zl);
    for (int i = top; i > top - n; i--) begin
      if (px[i]) send_bit(oh, ol);
      else send_bit(zh, zl);
    end
  endtask

  task automatic send_pixel(input logic [23:0] px);
    send_bits(px, 23, 24, 40, 22, 20, 42);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    tick(n);
  endtask

  initial begin
    logic [23:0] px;

    tick(3);
    check("rst_pixel", {g, r, b, pixel_index}, 32'h0);
    check("rst_flags", 32'({pixel_valid, frame_done, bit_error, dout}), 32'h0);
    rst_n = 1'b1;

    // Single pixel after the power-up latch gap
    gap(2600);
    mark();
    exp_q.push_back({24'h3F3F3F, 8'd0});
    send_pixel(24'h3F3F3F);
    gap(3000);
    expect_events("t1", 1, 0, 0);

    // Ten pixel frame; pixels 1..9 must be replayed on dout
    mark();
    n_drise = 0;
    for (int k = 0; k < 10; k++) begin
      px = {8'(k * 29 + 3), 8'(160 + k), 8'(255 - k * 7)};
      exp_q.push_back({px, 8'(k)});
      if (k == 1) fwd_exp = 1'b1;
      send_pixel(px);
    end
    gap(3000);
    fwd_exp = 1'b0;
    expect_events("t2", 1, 0, 0);
    check("t2_dout_pulses", 32'(n_drise), 32'd216);
    check("t2_dout_replay", 32'(dout_mism), 32'd0);

    // Runt pulse mid-pixel, then recovery on the following frame
    mark();
    px = 24'h5AC3E1;
    send_bits(px, 23, 10, 40, 22, 20, 42);
    send_bit(5, 30);
    send_bits(px, 13, 14, 40, 22, 20, 42);
    gap(3000);
    expect_events("t3_err", 0, 1, 0);
    mark();
    exp_q.push_back({24'h81FF00, 8'd0});
    send_pixel(24'h81FF00);
    gap(3000);
    expect_events("t3_next", 1, 0, 0);

    // Partial pixel terminated by the latch gap
    mark();
    send_bits(24'hFFF000, 23, 12, 40, 22, 20, 42);
    gap(3000);
    expect_events("t4", 1, 1, 1);
    check("t4_index", 32'(pixel_index), 32'd0);

    // Threshold: 30 ticks decodes 1, 29 decodes 0; then a 61-tick overlong high
    mark();
    exp_q.push_back({24'hA50FC3, 8'd0});
    send_bits(24'hA50FC3, 23, 24, 30, 30, 29, 33);
    gap(3000);
    send_bit(61, 10);
    gap(3000);
    expect_events("t5", 1, 1, 0);

    // Reset mid-pixel clears outputs at once; decode resumes only after a latch gap
    send_bits(24'h123456, 23, 10, 40, 22, 20, 42);
    din = 1'b1;
    tick(10);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pixel", {g, r, b, pixel_index}, 32'h0);
    check("t6_rst_flags", 32'({pixel_valid, frame_done, bit_error, dout}), 32'h0);
    @(negedge clk);
    din = 1'b0;
    tick(2);
    rst_n = 1'b1;
    mark();
    send_pixel(24'h777777);
    gap(3000);
    exp_q.push_back({24'hC0FFEE, 8'd0});
    send_pixel(24'hC0FFEE);
    gap(3000);
    expect_events("t6", 1, 0, 0);

    check("dout_total", 32'(dout_mism), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
